uart_rx: RTL and testbench

- Serial receive half of the SoC UART. Complements the transmit path that drives uart_tx.
- Samples the asynchronous uart_rx pin and deframes 8N1 characters, LSB first.
- Presents each byte on a one-entry valid/ready holding register and flags framing and overrun errors.
- Sits beside the UART block; its interrupt output feeds uart_int.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Even-parity bit for a data byte: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; RESET_VAL sets the reset level.
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: the first stage captures the raw input, the second stage follows the first.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer register chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input sync, half/full-bit down-counter timer, deframing FSM,
// one-entry valid/ready holding register with framing/overrun flags.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit (8E1) and the parity_err pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, recheck start bit (high = false start)
// DATA      | sample 8 data bits, LSB first
// PARITY    | sample parity bit, remember mismatch (UART_RX_PARITY_EN only)
// STOP      | sample stop bit; load/overrun on high, frame_err on low
// WAIT_HIGH | after framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 434,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      parity_err,
    output logic                      busy,
    output logic                      interrupt
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      strobe;
    logic                      pop;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, bit timer, shift register and holding-register handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        strobe = (cnt_q == '0);
        pop    = valid_q & rx_ready;

        if (pop) begin
            valid_d = 1'b0;
        end

        // Timer only runs while a frame is being sampled.
        if (state_q != IDLE && state_q != WAIT_HIGH) begin
            cnt_d = strobe ? FULL_LOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (strobe) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (strobe) begin
                    par_bad_d = (rx_s != even_parity(shift_q));
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (strobe) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        // A pop in this same cycle frees the register for the new byte.
                        if (!valid_q || pop) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timer, data path and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
    assign interrupt = valid_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT=16. Expected bytes go into a
// scoreboard queue as frames are sent; a negedge monitor pops on every handshake.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int CLK_HALF = 5;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT  = 171;  // 2 + 8 + 10*16 + 1
`else
    localparam int EXP_LAT  = 155;  // 2 + 8 + 9*16 + 1
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;
    logic       interrupt;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy),
        .interrupt  (interrupt)
    );

    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb_q[$];
    int f_cnt, o_cnt, p_cnt, busy_cnt, valid_cnt, intr_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_counts();
        f_cnt = 0; o_cnt = 0; p_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    endtask

    // Monitor: scoreboard pop on handshake, plus pulse/level counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                logic [8:0] e;
                e = (sb_q.size() > 0) ? {1'b0, sb_q.pop_front()} : 9'h1FF;
                check("sb_data", 32'(rx_data), 32'(e));
            end
            if (frame_err)  f_cnt++;
            if (overrun)    o_cnt++;
            if (parity_err) p_cnt++;
            if (busy)       busy_cnt++;
            if (rx_valid)   valid_cnt++;
            if (interrupt !== rx_valid) intr_bad++;
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Drives one frame; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
        logic pb;
        pb = par_good ? (^d) : ~(^d);
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pb);
`endif
        drive_bit(stop_b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(CLK_HALF * 2 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; intr_bad = 0;
        clear_counts();
        idle(3);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data",  32'(rx_data), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_flags", {29'b0, frame_err, overrun, parity_err}, 0);
        rst = 1'b0;
        idle(5);

        // Test 1: single byte, latency from the falling pin edge.
        clear_counts();
        sb_q.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge rx);
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk); #2;
                    lat++;
                    if (rx_valid) break;
                end
            end
        join
        idle(5);
        check("t1_latency", lat, EXP_LAT);
        check("t1_valid_cycles", valid_cnt, 1);
        check("t1_flags", f_cnt + o_cnt + p_cnt, 0);

        // Test 2: consumer stalled, second byte overruns.
        clear_counts();
        rx_ready = 1'b0;
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(10);
        check("t2_valid", 32'(rx_valid), 1);
        check("t2_data_held", 32'(rx_data), 32'h3C);
        check("t2_overrun", o_cnt, 1);
        rx_ready = 1'b1;
        idle(3);
        check("t2_valid_drop", 32'(rx_valid), 0);
        check("t2_sb_empty", sb_q.size(), 0);

        // Test 3: pop coincident with the stop strobe of the next byte.
        clear_counts();
        rx_ready = 1'b0;
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h55);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(4);
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
                @(negedge rx);
                repeat (EXP_LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(4);
        check("t3_valid_kept", 32'(rx_valid), 1);
        check("t3_data_new", 32'(rx_data), 32'h55);
        check("t3_no_overrun", o_cnt, 0);
        check("t3_one_popped", sb_q.size(), 1);
        rx_ready = 1'b1;
        idle(3);
        check("t3_sb_empty", sb_q.size(), 0);

        // Test 4: glitch, framing error, held break, recovery.
        clear_counts();
        @(posedge clk); #1 rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(30);
        check("t4_glitch_busy", busy_cnt, 8);
        check("t4_glitch_valid", valid_cnt, 0);
        check("t4_glitch_flags", f_cnt + o_cnt + p_cnt, 0);
        send_frame(8'h00, 1'b0, 1'b1);
        idle(100);
        check("t4_wait_busy", 32'(busy), 1);
        rx = 1'b1;
        idle(20);
        check("t4_frame_err", f_cnt, 1);
        check("t4_no_valid", valid_cnt, 0);
        check("t4_idle", 32'(busy), 0);
        sb_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(5);
        check("t4_sb_empty", sb_q.size(), 0);
        check("t4_frame_err_total", f_cnt, 1);

        // Test 5: async reset in the middle of DATA bit 4.
        clear_counts();
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                @(negedge rx);
                repeat (80) @(posedge clk);
                #1;
                check("t5_busy_before", 32'(busy), 1);
                rst = 1'b1;
                #1;
                check("t5_rst_busy", 32'(busy), 0);
                check("t5_rst_outputs", {22'b0, rx_data, rx_valid, frame_err}, 0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(10);
        check("t5_no_spurious", valid_cnt, 0);
        sb_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(5);
        check("t5_sb_empty", sb_q.size(), 0);
        check("t5_flags", f_cnt + o_cnt + p_cnt, 0);

`ifdef UART_RX_PARITY_EN
        // Test 6: parity bit wrong, then right.
        clear_counts();
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(5);
        check("t6_parity_err", p_cnt, 1);
        clear_counts();
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        check("t6_parity_ok", p_cnt, 0);
        check("t6_sb_empty", sb_q.size(), 0);
`endif

        check("interrupt_tracks_valid", intr_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
